fetch_decode_fifo: RTL and testbench

Registered FIFO between the instruction fetch stage and decode. It captures each fetched instruction with its PC, fault bits and pre-decoded class flags. It presents entries to decode in order under a valid/accept handshake and absorbs decode stalls without losing fetches. A squash flushes all in-flight entries on a branch redirect or exception.

---
 rtl/riscv_defs.sv | 25 ++
 rtl/fifo_ram.sv | 25 ++
 rtl/fetch_decode_fifo.sv | 79 +++++++
 tb/tb_fetch_decode_fifo.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/riscv_defs.sv
// Shared fetch/decode definitions: pre-decoded class bit positions and the
// fetch-queue entry layout.
package riscv_defs;

    localparam int CLASS_EXEC     = 0;
    localparam int CLASS_LSU      = 1;
    localparam int CLASS_BRANCH   = 2;
    localparam int CLASS_MUL      = 3;
    localparam int CLASS_DIV      = 4;
    localparam int CLASS_CSR      = 5;
    localparam int CLASS_RD_VALID = 6;
    localparam int CLASS_INVALID  = 7;

    localparam int ENTRY_W = 74;

    // MSB-first packing: instr, pc, fault_fetch, fault_page, class
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        fault_fetch;
        logic        fault_page;
        logic [7:0]  cls;
    } fetch_entry_t;

endpackage

// File: rtl/fifo_ram.sv
// Entry storage for the fetch queue: synchronous write, asynchronous read.
// Contents are deliberately not reset; pointers alone define validity.
module fifo_ram
    import riscv_defs::*;
#(
    parameter int DEPTH = 2,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic         clk_i,
    input  logic         we,
    input  logic [AW-1:0] waddr,
    input  fetch_entry_t wdata,
    input  logic [AW-1:0] raddr,
    output fetch_entry_t rdata
);

    fetch_entry_t mem [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_decode_fifo.sv
// Registered fetch-to-decode queue with valid/accept handshakes on both
// sides and a squash that drops every in-flight entry.
module fetch_decode_fifo
    import riscv_defs::*;
#(
    parameter int DEPTH = 2,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          fetch_in_valid_i,
    input  logic [31:0]   fetch_in_instr_i,
    input  logic [31:0]   fetch_in_pc_i,
    input  logic          fetch_in_fault_fetch_i,
    input  logic          fetch_in_fault_page_i,
    input  logic [7:0]    fetch_in_class_i,
    output logic          fetch_in_accept_o,
    input  logic          squash_i,
    output logic          fetch_out_valid_o,
    output logic [31:0]   fetch_out_instr_o,
    output logic [31:0]   fetch_out_pc_o,
    output logic          fetch_out_fault_fetch_o,
    output logic          fetch_out_fault_page_o,
    output logic [7:0]    fetch_out_class_o,
    input  logic          fetch_out_accept_i,
    output logic [AW:0]   level_o
);

    logic [AW:0]  wr_ptr, rd_ptr;
    logic         full, empty, push, pop;
    fetch_entry_t wr_entry, rd_entry;

    // Extra pointer MSB distinguishes full from empty when indices match.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

    // Accept depends on registered state only, so a full queue refuses
    // input even when decode drains it in the same cycle.
    assign fetch_in_accept_o = !full;
    assign fetch_out_valid_o = !empty;
    assign level_o           = wr_ptr - rd_ptr;

    assign push = fetch_in_valid_i && !full && !squash_i;
    assign pop  = !empty && fetch_out_accept_i && !squash_i;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (squash_i) begin
            rd_ptr <= wr_ptr;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    assign wr_entry = '{instr:       fetch_in_instr_i,
                        pc:          fetch_in_pc_i,
                        fault_fetch: fetch_in_fault_fetch_i,
                        fault_page:  fetch_in_fault_page_i,
                        cls:         fetch_in_class_i};

    fifo_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
        .clk_i (clk_i),
        .we    (push),
        .waddr (wr_ptr[AW-1:0]),
        .wdata (wr_entry),
        .raddr (rd_ptr[AW-1:0]),
        .rdata (rd_entry)
    );

    assign fetch_out_instr_o       = rd_entry.instr;
    assign fetch_out_pc_o          = rd_entry.pc;
    assign fetch_out_fault_fetch_o = rd_entry.fault_fetch;
    assign fetch_out_fault_page_o  = rd_entry.fault_page;
    assign fetch_out_class_o       = rd_entry.cls;

endmodule

// File: tb/tb_fetch_decode_fifo.sv
// Bench for fetch_decode_fifo: queue-based model checked after every edge,
// directed scenarios with literal expectations, then randomized traffic.
module tb_fetch_decode_fifo;

    localparam int DEPTH = 2;
    localparam int AW    = $clog2(DEPTH);

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        fetch_in_valid_i = 1'b0;
    logic [31:0] fetch_in_instr_i = '0;
    logic [31:0] fetch_in_pc_i = '0;
    logic        fetch_in_fault_fetch_i = 1'b0;
    logic        fetch_in_fault_page_i = 1'b0;
    logic [7:0]  fetch_in_class_i = '0;
    logic        fetch_in_accept_o;
    logic        squash_i = 1'b0;
    logic        fetch_out_valid_o;
    logic [31:0] fetch_out_instr_o;
    logic [31:0] fetch_out_pc_o;
    logic        fetch_out_fault_fetch_o;
    logic        fetch_out_fault_page_o;
    logic [7:0]  fetch_out_class_o;
    logic        fetch_out_accept_i = 1'b0;
    logic [AW:0] level_o;

    fetch_decode_fifo #(.DEPTH(DEPTH)) dut (
        .clk_i                   (clk_i),
        .rst_i                   (rst_i),
        .fetch_in_valid_i        (fetch_in_valid_i),
        .fetch_in_instr_i        (fetch_in_instr_i),
        .fetch_in_pc_i           (fetch_in_pc_i),
        .fetch_in_fault_fetch_i  (fetch_in_fault_fetch_i),
        .fetch_in_fault_page_i   (fetch_in_fault_page_i),
        .fetch_in_class_i        (fetch_in_class_i),
        .fetch_in_accept_o       (fetch_in_accept_o),
        .squash_i                (squash_i),
        .fetch_out_valid_o       (fetch_out_valid_o),
        .fetch_out_instr_o       (fetch_out_instr_o),
        .fetch_out_pc_o          (fetch_out_pc_o),
        .fetch_out_fault_fetch_o (fetch_out_fault_fetch_o),
        .fetch_out_fault_page_o  (fetch_out_fault_page_o),
        .fetch_out_class_o       (fetch_out_class_o),
        .fetch_out_accept_i      (fetch_out_accept_i),
        .level_o                 (level_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        ff;
        logic        fp;
        logic [7:0]  cls;
    } ent_t;

    ent_t q[$];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare every visible output against the model queue.
    task automatic check_model();
        int n;
        n = q.size();
        chk("valid", 64'(fetch_out_valid_o), 64'(n != 0));
        chk("accept", 64'(fetch_in_accept_o), 64'(n < DEPTH));
        chk("level", 64'(level_o), 64'(n));
        if (n != 0 && fetch_out_valid_o) begin
            chk("instr", 64'(fetch_out_instr_o), 64'(q[0].instr));
            chk("pc", 64'(fetch_out_pc_o), 64'(q[0].pc));
            chk("fault_fetch", 64'(fetch_out_fault_fetch_o), 64'(q[0].ff));
            chk("fault_page", 64'(fetch_out_fault_page_o), 64'(q[0].fp));
            chk("class", 64'(fetch_out_class_o), 64'(q[0].cls));
        end
    endtask

    task automatic offer(input logic v, input logic [31:0] pc, input logic [31:0] instr,
                         input logic ff, input logic fp, input logic [7:0] cls);
        fetch_in_valid_i       = v;
        fetch_in_pc_i          = pc;
        fetch_in_instr_i       = instr;
        fetch_in_fault_fetch_i = ff;
        fetch_in_fault_page_i  = fp;
        fetch_in_class_i       = cls;
    endtask

    // Decide the model's transfers from pre-edge state, clock, then check.
    task automatic cycle();
        bit   do_push, do_pop, sq;
        ent_t e;
        sq      = squash_i;
        do_push = fetch_in_valid_i && (q.size() < DEPTH) && !sq;
        do_pop  = (q.size() != 0) && fetch_out_accept_i && !sq;
        e = '{instr: fetch_in_instr_i, pc: fetch_in_pc_i, ff: fetch_in_fault_fetch_i,
              fp: fetch_in_fault_page_i, cls: fetch_in_class_i};
        @(posedge clk_i);
        if (sq) q.delete();
        else begin
            if (do_pop)  void'(q.pop_front());
            if (do_push) q.push_back(e);
        end
        #1;
        check_model();
    endtask

    initial begin
        // Reset state, then release between edges.
        #2;
        chk("rst_valid", 64'(fetch_out_valid_o), 64'd0);
        chk("rst_accept", 64'(fetch_in_accept_o), 64'd1);
        chk("rst_level", 64'(level_o), 64'd0);
        #10 rst_i = 1'b1;

        // Fill/drain with decode stalled.
        fetch_out_accept_i = 1'b0;
        offer(1, 32'h0, 32'h13, 0, 0, 8'h01); cycle();
        offer(1, 32'h4, 32'h13, 0, 0, 8'h01); cycle();
        offer(0, 32'h0, 32'h0, 0, 0, 8'h00);
        chk("fill_accept", 64'(fetch_in_accept_o), 64'd0);
        chk("fill_level", 64'(level_o), 64'd2);
        chk("fill_head", 64'(fetch_out_pc_o), 64'h0);
        fetch_out_accept_i = 1'b1;
        cycle();
        chk("drain_pc1", 64'(fetch_out_pc_o), 64'h4);
        cycle();
        chk("drain_empty", 64'(fetch_out_valid_o), 64'd0);

        // Streaming at one per cycle with decode always accepting.
        for (int i = 0; i < 8; i++) begin
            offer(1, 32'(i * 4), 32'h13, 0, 0, 8'h01);
            cycle();
            chk("stream_level", 64'(level_o), 64'd1);
            chk("stream_pc", 64'(fetch_out_pc_o), 64'(i * 4));
        end
        offer(0, 32'h0, 32'h0, 0, 0, 8'h00); cycle();

        // Full with pop: offer refused that cycle, taken the next.
        fetch_out_accept_i = 1'b0;
        offer(1, 32'h8, 32'h13, 0, 0, 8'h01); cycle();
        offer(1, 32'hC, 32'h13, 0, 0, 8'h01); cycle();
        fetch_out_accept_i = 1'b1;
        offer(1, 32'h10, 32'h13, 0, 0, 8'h01); cycle();
        chk("fullpop_level", 64'(level_o), 64'd1);
        chk("fullpop_head", 64'(fetch_out_pc_o), 64'hC);
        fetch_out_accept_i = 1'b0;
        cycle();
        chk("fullpop_level2", 64'(level_o), 64'd2);

        // Squash from full with a concurrent offer and pop.
        squash_i = 1'b1; fetch_out_accept_i = 1'b1;
        offer(1, 32'h20, 32'h13, 0, 0, 8'h01); cycle();
        chk("squash_valid", 64'(fetch_out_valid_o), 64'd0);
        chk("squash_level", 64'(level_o), 64'd0);
        squash_i = 1'b0; fetch_out_accept_i = 1'b0;
        offer(1, 32'h40, 32'h13, 0, 0, 8'h01); cycle();
        chk("post_squash_level", 64'(level_o), 64'd1);
        chk("post_squash_pc", 64'(fetch_out_pc_o), 64'h40);
        offer(0, 32'h0, 32'h0, 0, 0, 8'h00); fetch_out_accept_i = 1'b1; cycle();

        // Field integrity.
        offer(1, 32'h100, 32'h00500093, 0, 0, 8'h41); cycle();
        chk("f1_instr", 64'(fetch_out_instr_o), 64'h00500093);
        chk("f1_class", 64'(fetch_out_class_o), 64'h41);
        offer(1, 32'h104, 32'h0000006F, 0, 0, 8'h45); cycle();
        chk("f2_instr", 64'(fetch_out_instr_o), 64'h0000006F);
        chk("f2_class", 64'(fetch_out_class_o), 64'h45);
        offer(1, 32'h108, 32'hDEADBEEF, 0, 1, 8'h80); cycle();
        chk("f3_pc", 64'(fetch_out_pc_o), 64'h108);
        chk("f3_page", 64'(fetch_out_fault_page_o), 64'd1);
        chk("f3_fetch", 64'(fetch_out_fault_fetch_o), 64'd0);
        chk("f3_class", 64'(fetch_out_class_o), 64'h80);
        offer(0, 32'h0, 32'h0, 0, 0, 8'h00); cycle();

        // Async reset mid-stream with one entry held.
        fetch_out_accept_i = 1'b0;
        offer(1, 32'h200, 32'h13, 0, 0, 8'h01); cycle();
        offer(0, 32'h0, 32'h0, 0, 0, 8'h00);
        chk("pre_reset_level", 64'(level_o), 64'd1);
        #3 rst_i = 1'b0;
        #1;
        chk("arst_valid", 64'(fetch_out_valid_o), 64'd0);
        chk("arst_accept", 64'(fetch_in_accept_o), 64'd1);
        chk("arst_level", 64'(level_o), 64'd0);
        q.delete();
        #2 rst_i = 1'b1;

        // Pointer wrap-around, in order.
        fetch_out_accept_i = 1'b1;
        for (int i = 0; i < 5 * DEPTH; i++) begin
            offer(1, 32'h300 + 32'(i * 4), 32'(i), 0, 0, 8'h01);
            cycle();
            chk("wrap_pc", 64'(fetch_out_pc_o), 64'h300 + 64'(i * 4));
        end

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            offer(1'($urandom_range(0, 3) != 0), $urandom, $urandom,
                  1'($urandom), 1'($urandom), 8'($urandom));
            fetch_out_accept_i = 1'($urandom_range(0, 2) != 0);
            squash_i           = ($urandom_range(0, 19) == 0);
            cycle();
        end
        squash_i = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
